// File: rtl/cpu_pkg.sv
// cpu_pkg: shared width and ALU opcode constants for the phase-1 CPU datapath.
// Ports: none (package only).
package cpu_pkg;

  localparam int DATA_W = 32;

  // Opcodes live in IR[31:27]
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_SHRA = 5'd10;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_MUL  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU producing a 2*DATA_W result for the Z register.
// Ports:
//   a_i      - operand A (from Y)
//   b_i      - operand B (from the bus)
//   op_i     - opcode (IR[31:27])
//   result_o - {Zhigh, Zlow}; upper half is non-zero only for MUL and DIV
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  input  logic [4:0]          op_i,
  output logic [2*DATA_W-1:0] result_o
);

  logic [4:0]            sh;
  logic [5:0]            sh_inv;
  logic [DATA_W-1:0]     quo;
  logic [DATA_W-1:0]     rem;
  logic [2*DATA_W-1:0]   prod;

  assign sh     = b_i[4:0];
  // Shift by 32 when sh==0 yields zero, so rotate-by-0 returns A unchanged
  assign sh_inv = 6'd32 - {1'b0, sh};

  assign prod = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) *
                $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});

  // Divide by zero is defined as quotient 0, remainder A
  always_comb begin
    quo = '0;
    rem = a_i;
    if (b_i != '0) begin
      quo = $signed(a_i) / $signed(b_i);
      rem = $signed(a_i) % $signed(b_i);
    end
  end

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o[DATA_W-1:0] = a_i + b_i;
      OP_SUB:  result_o[DATA_W-1:0] = a_i - b_i;
      OP_AND:  result_o[DATA_W-1:0] = a_i & b_i;
      OP_OR:   result_o[DATA_W-1:0] = a_i | b_i;
      OP_ROR:  result_o[DATA_W-1:0] = (a_i >> sh) | (a_i << sh_inv);
      OP_ROL:  result_o[DATA_W-1:0] = (a_i << sh) | (a_i >> sh_inv);
      OP_SHR:  result_o[DATA_W-1:0] = a_i >> sh;
      OP_SHRA: result_o[DATA_W-1:0] = $signed(a_i) >>> sh;
      OP_SHL:  result_o[DATA_W-1:0] = a_i << sh;
      OP_DIV:  result_o = {rem, quo};
      OP_MUL:  result_o = prod;
      OP_NEG:  result_o[DATA_W-1:0] = -b_i;
      OP_NOT:  result_o[DATA_W-1:0] = ~b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: 32-bit single-bus datapath driven directly by control strobes.
// Ports:
//   clock, clear          - clock and asynchronous active-high clear
//   Rnout / Rnin          - drive / load general register n (n = 0..15)
//   PCout, IncPC          - drive PC onto the bus / increment PC
//   MARin, IRin, Yin      - load MAR / IR / Y from the bus
//   MDRin, MDRout,memRead - load MDR (from mDataIn when memRead, else bus) / drive MDR
//   Zin, Zhighout, Zlowout- load 64-bit Z from ALU / drive its halves
//   HIin, LOin, HIout, LOout - load / drive HI and LO
//   mDataIn, mDataOut     - memory read data in / MDR contents out
module cpu_datapath
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              IncPC,
  input  logic              R0out,  R1out,  R2out,  R3out,
  input  logic              R4out,  R5out,  R6out,  R7out,
  input  logic              R8out,  R9out,  R10out, R11out,
  input  logic              R12out, R13out, R14out, R15out,
  input  logic              R0in,   R1in,   R2in,   R3in,
  input  logic              R4in,   R5in,   R6in,   R7in,
  input  logic              R8in,   R9in,   R10in,  R11in,
  input  logic              R12in,  R13in,  R14in,  R15in,
  input  logic              MARin,
  input  logic              MDRout,
  input  logic              MDRin,
  input  logic              memRead,
  input  logic [DATA_W-1:0] mDataIn,
  output logic [DATA_W-1:0] mDataOut,
  input  logic              PCout,
  input  logic              Zin,
  input  logic              Zhighout,
  input  logic              Zlowout,
  input  logic              HIin,
  input  logic              LOin,
  input  logic              HIout,
  input  logic              LOout,
  input  logic              Yin,
  input  logic              IRin
);

  logic [15:0]           r_out_sel;
  logic [15:0]           r_in_sel;
  logic [DATA_W-1:0]     r_q [16];
  logic [DATA_W-1:0]     pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q;
  logic [2*DATA_W-1:0]   z_q;
  logic [DATA_W-1:0]     bus;
  logic [DATA_W-1:0]     mdr_d;
  logic [DATA_W-1:0]     pc_d;
  logic [2*DATA_W-1:0]   alu_result;
  logic                  unused_fields;

  assign r_out_sel = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                      R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
  assign r_in_sel  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                      R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

  // Later assignments override earlier ones, giving
  // MDR > PC > Zlow > Zhigh > LO > HI > R15 ... R0; idle bus reads 0.
  always_comb begin
    bus = '0;
    for (int i = 0; i < 16; i++) begin
      if (r_out_sel[i]) bus = r_q[i];
    end
    if (HIout)    bus = hi_q;
    if (LOout)    bus = lo_q;
    if (Zhighout) bus = z_q[2*DATA_W-1:DATA_W];
    if (Zlowout)  bus = z_q[DATA_W-1:0];
    if (PCout)    bus = pc_q;
    if (MDRout)   bus = mdr_q;
  end

  assign mdr_d = memRead ? mDataIn : bus;
  assign pc_d  = pc_q + 1'b1;

  cpu_alu u_alu (
    .a_i      (y_q),
    .b_i      (bus),
    .op_i     (ir_q[31:27]),
    .result_o (alu_result)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      z_q   <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (r_in_sel[i]) r_q[i] <= bus;
      end
      if (IncPC) pc_q  <= pc_d;
      if (IRin)  ir_q  <= bus;
      if (MARin) mar_q <= bus;
      if (MDRin) mdr_q <= mdr_d;
      if (Yin)   y_q   <= bus;
      if (HIin)  hi_q  <= bus;
      if (LOin)  lo_q  <= bus;
      if (Zin)   z_q   <= alu_result;
    end
  end

  assign mDataOut = mdr_q;

  // ra/rb/rc fields of IR and the MAR address are consumed by the future
  // control unit and memory interface; they are held but not read here.
  assign unused_fields = ^{ir_q[26:0], mar_q};

endmodule

// File: tb/tb_cpu_datapath.sv
module tb_cpu_datapath;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        clear;
  logic        IncPC, MARin, MDRout, MDRin, memRead, PCout;
  logic        Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Yin, IRin;
  logic [15:0] rout, rin;
  logic [31:0] mDataIn, mDataOut;

  int errors = 0;
  int checks = 0;
  logic [31:0] v;

  cpu_datapath dut (
    .clock(clock), .clear(clear), .IncPC(IncPC),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
    .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
    .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .R0in(rin[0]),     .R1in(rin[1]),     .R2in(rin[2]),     .R3in(rin[3]),
    .R4in(rin[4]),     .R5in(rin[5]),     .R6in(rin[6]),     .R7in(rin[7]),
    .R8in(rin[8]),     .R9in(rin[9]),     .R10in(rin[10]),   .R11in(rin[11]),
    .R12in(rin[12]),   .R13in(rin[13]),   .R14in(rin[14]),   .R15in(rin[15]),
    .MARin(MARin), .MDRout(MDRout), .MDRin(MDRin), .memRead(memRead),
    .mDataIn(mDataIn), .mDataOut(mDataOut), .PCout(PCout),
    .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
    .Yin(Yin), .IRin(IRin)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic idle();
    IncPC = 0; MARin = 0; MDRout = 0; MDRin = 0; memRead = 0; PCout = 0;
    Zin = 0; Zhighout = 0; Zlowout = 0; HIin = 0; LOin = 0; HIout = 0;
    LOout = 0; Yin = 0; IRin = 0; rout = '0; rin = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic put_mdr(input logic [31:0] val);
    memRead = 1; mDataIn = val; MDRin = 1;
    tick();
  endtask

  task automatic load_reg(input int n, input logic [31:0] val);
    put_mdr(val);
    MDRout = 1; rin[n] = 1;
    tick();
  endtask

  // Caller asserts the source strobe; the bus value is captured into MDR
  task automatic read_bus(output logic [31:0] val);
    MDRin = 1; memRead = 0;
    tick();
    val = mDataOut;
  endtask

  task automatic read_reg(input int n, output logic [31:0] val);
    rout[n] = 1;
    read_bus(val);
  endtask

  task automatic alu_check(input string tag, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
    logic [31:0] r;
    put_mdr({op, 27'b0});
    MDRout = 1; IRin = 1; tick();
    put_mdr(a);
    MDRout = 1; Yin = 1; tick();
    put_mdr(b);
    MDRout = 1; Zin = 1; tick();
    Zlowout = 1; read_bus(r);
    check({tag, "_zlo"}, {32'b0, r}, {32'b0, exp[31:0]});
    Zhighout = 1; read_bus(r);
    check({tag, "_zhi"}, {32'b0, r}, {32'b0, exp[63:32]});
  endtask

  initial begin
    idle();
    mDataIn = '0;
    clear = 1;
    #3;
    check("reset_mdataout", {32'b0, mDataOut}, 64'd0);
    @(posedge clock); #1;
    clear = 0;

    PCout = 1; read_bus(v);
    check("reset_pc", {32'b0, v}, 64'd0);

    // ADD walkthrough
    load_reg(2, 32'd21);
    load_reg(3, 32'd5);
    PCout = 1; MARin = 1; IncPC = 1; tick();
    check("t0_mar", {32'b0, dut.mar_q}, 64'd0);
    PCout = 1; read_bus(v);
    check("t0_pc", {32'b0, v}, 64'd1);
    put_mdr(32'h18918000);
    MDRout = 1; IRin = 1; tick();
    rout[2] = 1; Yin = 1; tick();
    rout[3] = 1; Zin = 1; tick();
    Zlowout = 1; rin[1] = 1; tick();
    read_reg(1, v);
    check("add_r1", {32'b0, v}, 64'd26);
    Zhighout = 1; read_bus(v);
    check("add_zhi", {32'b0, v}, 64'd0);

    alu_check("add_wrap", OP_ADD, 32'hFFFFFFFF, 32'd1, 64'd0);
    alu_check("sub", OP_SUB, 32'd5, 32'd21, 64'h00000000_FFFFFFF0);
    alu_check("neg", OP_NEG, 32'd5, 32'd1, 64'h00000000_FFFFFFFF);
    alu_check("not", OP_NOT, 32'd0, 32'h0000FFFF, 64'h00000000_FFFF0000);
    alu_check("and", OP_AND, 32'hF0F000FF, 32'h0FF00F0F, 64'h00000000_00F0000F);
    alu_check("or",  OP_OR,  32'hF0F000FF, 32'h0FF00F0F, 64'h00000000_FFF00FFF);

    alu_check("mul", OP_MUL, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
    Zhighout = 1; HIin = 1; tick();
    Zlowout = 1; LOin = 1; tick();
    HIout = 1; read_bus(v);
    check("hi", {32'b0, v}, 64'hFFFFFFFF);
    LOout = 1; read_bus(v);
    check("lo", {32'b0, v}, 64'hFFFFFFEB);

    alu_check("div",      OP_DIV, 32'd22, 32'd5, {32'd2, 32'd4});
    alu_check("div_zero", OP_DIV, 32'd22, 32'd0, {32'd22, 32'd0});
    alu_check("div_neg",  OP_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);

    alu_check("shr",  OP_SHR,  32'h80000001, 32'd1, 64'h0000_0000_4000_0000);
    alu_check("shra", OP_SHRA, 32'h80000001, 32'd1, 64'h0000_0000_C000_0000);
    alu_check("shl",  OP_SHL,  32'h80000001, 32'd1, 64'h0000_0000_0000_0002);
    alu_check("ror",  OP_ROR,  32'h80000001, 32'd1, 64'h0000_0000_C000_0000);
    alu_check("rol",  OP_ROL,  32'h80000001, 32'd1, 64'h0000_0000_0000_0003);
    alu_check("ror0", OP_ROR,  32'h80000001, 32'd0, 64'h0000_0000_8000_0001);
    alu_check("bad_op", 5'd0,  32'd9, 32'd9, 64'd0);

    // Bus idle and priority
    load_reg(4, 32'h55);
    rin[4] = 1; tick();
    read_reg(4, v);
    check("bus_idle_r4", {32'b0, v}, 64'd0);
    load_reg(2, 32'h77);
    put_mdr(32'h99);
    MDRout = 1; rout[2] = 1; rin[7] = 1; tick();
    read_reg(7, v);
    check("prio_mdr_over_r2", {32'b0, v}, 64'h99);
    load_reg(8, 32'h1234);
    PCout = 1; rout[8] = 1; rin[9] = 1; tick();
    read_reg(9, v);
    check("prio_pc_over_r8", {32'b0, v}, 64'd1);

    // Reset mid-operation
    load_reg(5, 32'h1234);
    read_reg(5, v);
    check("pre_clear_r5", {32'b0, v}, 64'h1234);
    clear = 1;
    #2;
    check("clear_immediate", {32'b0, mDataOut}, 64'd0);
    memRead = 1; mDataIn = 32'hABCD; MDRin = 1; IncPC = 1;
    @(posedge clock); #1;
    idle();
    clear = 0;
    check("clear_blocks_mdr", {32'b0, mDataOut}, 64'd0);
    read_reg(5, v);
    check("clear_r5", {32'b0, v}, 64'd0);
    PCout = 1; read_bus(v);
    check("clear_pc", {32'b0, v}, 64'd0);
    HIout = 1; read_bus(v);
    check("clear_hi", {32'b0, v}, 64'd0);
    check("clear_mar", {32'b0, dut.mar_q}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
